// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 fetch stage: NOP encoding, boot address,
// fetch FSM states and the {pc, instr} buffer entry.
package msrv32_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN,
    ST_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Two-entry {pc, instr} buffer with the head held in slot0; push and pop may
// coincide, and clear overrides both.
module msrv32_fetch_fifo
  import msrv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   cnt;
  logic         pop_eff;
  logic         push_eff;

  assign pop_eff  = pop && (cnt != 2'd0);
  assign push_eff = push && ((cnt != 2'd2) || pop_eff);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + {1'b0, push_eff} - {1'b0, pop_eff};
    end
  end

  // Slot contents are not reset: cnt alone decides which slots are live.
  always_ff @(posedge clk) begin
    case (cnt)
      2'd0: begin
        if (push_eff) slot0 <= din;
      end
      2'd1: begin
        if (push_eff && pop_eff) slot0 <= din;
        else if (push_eff)       slot1 <= din;
      end
      default: begin
        if (pop_eff)  slot0 <= slot1;
        if (push_eff) slot1 <= din;
      end
    endcase
  end

  assign head  = slot0;
  assign count = cnt;

endmodule

// File: rtl/msrv32_fetch_unit.sv
// msrv32 instruction fetch: PC ownership, single-outstanding imem handshake,
// two-deep instruction buffer and redirect/misalignment handling.
module msrv32_fetch_unit
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic        misaligned_out
);

  fetch_state_t state;
  logic         halt_pending;
  logic [31:0]  req_pc;
  logic [31:0]  last_pc;
  logic         accepted;
  logic         outstanding_after;
  logic         misaligned_target;
  logic         push;
  logic         pop;
  logic         room;
  logic [1:0]   count;
  logic [1:0]   count_next;
  fetch_entry_t head;
  fetch_entry_t din;

  assign accepted          = (state == ST_FETCH) && imem_req_out && imem_ready_in;
  assign misaligned_target = |redirect_pc_in[1:0];
  // A response landing in the redirect cycle settles the old request, so no drain is needed.
  assign outstanding_after = accepted ||
                             (((state == ST_WAIT) || (state == ST_DRAIN)) && !imem_rvalid_in);
  assign push              = (state == ST_WAIT) && imem_rvalid_in && !redirect_in;
  assign pop               = (count != 2'd0) && !stall_in;
  assign din               = {req_pc, imem_rdata_in};

  always_comb begin
    count_next = count;
    if (redirect_in)       count_next = 2'd0;
    else if (push && !pop) count_next = count + 2'd1;
    else if (!push && pop) count_next = count - 2'd1;
  end

  assign room = (count_next < 2'd2);

  msrv32_fetch_fifo u_fifo (
    .clk   (ms_riscv32_mp_clk_in),
    .rst   (ms_riscv32_mp_rst_in),
    .push  (push),
    .pop   (pop),
    .clear (redirect_in),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (accepted) req_pc <= imem_addr_out;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state          <= ST_BOOT;
      imem_req_out   <= 1'b0;
      imem_addr_out  <= BOOT_ADDR;
      misaligned_out <= 1'b0;
      halt_pending   <= 1'b0;
      last_pc        <= BOOT_ADDR;
    end else begin
      if (count != 2'd0) last_pc <= head.pc;
      if (redirect_in) begin
        if (misaligned_target) begin
          misaligned_out <= 1'b1;
          halt_pending   <= 1'b1;
          imem_req_out   <= 1'b0;
          state          <= outstanding_after ? ST_DRAIN : ST_HALT;
        end else begin
          misaligned_out <= 1'b0;
          halt_pending   <= 1'b0;
          imem_addr_out  <= redirect_pc_in;
          imem_req_out   <= !outstanding_after;
          state          <= outstanding_after ? ST_DRAIN : ST_FETCH;
        end
      end else begin
        case (state)
          ST_BOOT: begin
            state        <= ST_FETCH;
            imem_req_out <= room;
          end
          ST_FETCH: begin
            if (accepted) begin
              state         <= ST_WAIT;
              imem_req_out  <= 1'b0;
              imem_addr_out <= imem_addr_out + 32'd4;
            end else begin
              imem_req_out <= room;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid_in) begin
              state        <= ST_FETCH;
              imem_req_out <= room;
            end
          end
          ST_DRAIN: begin
            if (imem_rvalid_in) begin
              state        <= halt_pending ? ST_HALT : ST_FETCH;
              imem_req_out <= !halt_pending && room;
            end
          end
          ST_HALT: begin
            imem_req_out <= 1'b0;
          end
          default: begin
            state        <= ST_BOOT;
            imem_req_out <= 1'b0;
          end
        endcase
      end
    end
  end

  assign flush_out = (count == 2'd0);
  assign instr_out = flush_out ? NOP_INSTR : head.instr;
  assign pc_out    = flush_out ? last_pc : head.pc;

endmodule

// File: tb/tb_msrv32_fetch_unit.sv
// Bench for msrv32_fetch_unit: cycle table against a zero-wait memory, then
// randomized traffic checked against an instruction-stream reference model.
module tb_msrv32_fetch_unit;
  import msrv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        stall_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        flush_out;
  logic        misaligned_out;

  always #5 clk = ~clk;

  msrv32_fetch_unit #(.BOOT_ADDR(32'h0000_0000)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .imem_req_out         (imem_req_out),
    .imem_addr_out        (imem_addr_out),
    .imem_ready_in        (imem_ready_in),
    .imem_rvalid_in       (imem_rvalid_in),
    .imem_rdata_in        (imem_rdata_in),
    .redirect_in          (redirect_in),
    .redirect_pc_in       (redirect_pc_in),
    .stall_in             (stall_in),
    .instr_out            (instr_out),
    .pc_out               (pc_out),
    .flush_out            (flush_out),
    .misaligned_out       (misaligned_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        hold;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  // Memory model state: at most one accepted request awaiting its response.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return a ^ 32'hDEAD_0003;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input int r, input int s, input int d, input logic [31:0] rpc, input int h,
                     input int q, input logic [31:0] a, input int f, input logic [31:0] p,
                     input int m);
    vec_t v;
    v.rst = (r != 0);  v.stall = (s != 0);  v.redir = (d != 0);  v.rpc = rpc;
    v.hold = (h != 0); v.e_req = (q != 0);  v.e_addr = a;        v.e_flush = (f != 0);
    v.e_pc = p;        v.e_mis = (m != 0);
    vecs.push_back(v);
  endtask

  logic        r_stall, r_redir;
  logic [31:0] r_tgt;
  logic [31:0] exp_pc, hold_pc;
  logic        mis_m;
  int          gap;
  int          sel;

  initial begin
    //  rst stall redir rpc          hold | req addr          flush pc            mis
    add(0, 0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h0,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h4,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h8,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h8,          0, 32'h4,          0);
    add(0, 0, 1, 32'h100,        0,   0, 32'hC,          1, 32'h4,          0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h100,        1, 32'h4,          0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h104,        1, 32'h4,          0);
    add(0, 1, 0, 32'h0,          0,   1, 32'h104,        0, 32'h100,        0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 32'h0,        0,   0, 32'h108,        0, 32'h100,        0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h108,        0, 32'h100,        0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h108,        0, 32'h104,        0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h10C,        1, 32'h104,        0);
    add(0, 0, 1, 32'h102,        0,   1, 32'h10C,        0, 32'h108,        0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h10C,        1, 32'h108,        1);
    add(0, 0, 0, 32'h0,          0,   0, 32'h10C,        1, 32'h108,        1);
    add(0, 0, 1, 32'h200,        0,   0, 32'h10C,        1, 32'h108,        1);
    add(0, 0, 0, 32'h0,          0,   1, 32'h200,        1, 32'h108,        0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h204,        1, 32'h108,        0);
    add(0, 0, 1, 32'hFFFF_FFFC,  0,   1, 32'h204,        0, 32'h200,        0);
    add(0, 0, 0, 32'h0,          0,   0, 32'hFFFF_FFFC,  1, 32'h200,        0);
    add(0, 0, 0, 32'h0,          0,   1, 32'hFFFF_FFFC,  1, 32'h200,        0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h200,        0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h0,          0, 32'hFFFF_FFFC,  0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h4,          1, 32'hFFFF_FFFC,  0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0,          0);
    add(1, 0, 0, 32'h0,          1,   0, 32'h8,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h0,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h4,          1, 32'h0,          0);
    add(0, 0, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0,          0);

    rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
    imem_ready_in = 1'b0; imem_rvalid_in = 1'b0; imem_rdata_in = '0;
    pend = 1'b0; pend_addr = '0; pend_wait = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      stall_in       = vecs[i].stall;
      redirect_in    = vecs[i].redir;
      redirect_pc_in = vecs[i].rpc;
      imem_ready_in  = 1'b1;
      imem_rvalid_in = pend && !vecs[i].hold;
      imem_rdata_in  = imem_rvalid_in ? mem_word(pend_addr) : $urandom;
      #1;
      check1 ($sformatf("v%0d req", i),   imem_req_out,   vecs[i].e_req);
      check32($sformatf("v%0d addr", i),  imem_addr_out,  vecs[i].e_addr);
      check1 ($sformatf("v%0d flush", i), flush_out,      vecs[i].e_flush);
      check32($sformatf("v%0d pc", i),    pc_out,         vecs[i].e_pc);
      check32($sformatf("v%0d instr", i), instr_out,
              vecs[i].e_flush ? NOP_INSTR : mem_word(vecs[i].e_pc));
      check1 ($sformatf("v%0d mis", i),   misaligned_out, vecs[i].e_mis);
      if (imem_rvalid_in) pend = 1'b0;
      if (imem_req_out && imem_ready_in) begin
        pend      = 1'b1;
        pend_addr = imem_addr_out;
      end
      @(posedge clk);
      #1;
    end

    // Randomized traffic: the delivered stream must be target, target+4, ... after each redirect.
    rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; imem_ready_in = 1'b0; imem_rvalid_in = 1'b0;
    pend = 1'b0; pend_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 32'h0; hold_pc = 32'h0; mis_m = 1'b0; gap = 0;

    for (int c = 0; c < 3000; c++) begin
      r_stall = (($urandom % 4) == 0);
      r_redir = (($urandom % 30) == 0);
      sel     = int'($urandom % 8);
      if (sel == 0)      r_tgt = 32'hFFFF_FFF0 + ($urandom % 4) * 4;
      else if (sel == 1) r_tgt = ($urandom & 32'h0000_0FFC) | $urandom_range(1, 3);
      else               r_tgt = $urandom & 32'h0000_0FFC;
      stall_in       = r_stall;
      redirect_in    = r_redir;
      redirect_pc_in = r_tgt;
      imem_rvalid_in = pend && (pend_wait == 0);
      imem_rdata_in  = imem_rvalid_in ? mem_word(pend_addr) : $urandom;
      imem_ready_in  = (($urandom % 4) != 0);
      #1;
      check1("rnd mis", misaligned_out, mis_m);
      if (mis_m) begin
        check1("rnd halt req", imem_req_out, 1'b0);
        check1("rnd halt flush", flush_out, 1'b1);
      end
      if (flush_out) begin
        check32("rnd nop", instr_out, NOP_INSTR);
        check32("rnd hold pc", pc_out, hold_pc);
      end else begin
        check32("rnd pc", pc_out, exp_pc);
        check32("rnd instr", instr_out, mem_word(exp_pc));
      end
      if (imem_req_out) check32("rnd addr align", {30'd0, imem_addr_out[1:0]}, 32'h0);
      if (!mis_m) begin
        total++;
        if (gap > 40) begin
          bad++;
          $display("FAIL rnd progress: no instruction for %0d cycles, required at most 40", gap);
          gap = 0;
        end
      end

      if (!flush_out) begin
        hold_pc = exp_pc;
        gap     = 0;
      end else begin
        gap++;
      end
      if (r_redir) begin
        if (r_tgt[1:0] == 2'b00) begin
          exp_pc = r_tgt;
          mis_m  = 1'b0;
        end else begin
          mis_m = 1'b1;
        end
        gap = 0;
      end else if (!flush_out && !r_stall) begin
        exp_pc = exp_pc + 32'd4;
      end

      if (imem_rvalid_in) pend = 1'b0;
      else if (pend && pend_wait > 0) pend_wait--;
      if (imem_req_out && imem_ready_in) begin
        total++;
        if (pend) begin
          bad++;
          $display("FAIL rnd single outstanding: got 2 requests in flight, required at most 1");
        end
        pend      = 1'b1;
        pend_addr = imem_addr_out;
        pend_wait = int'($urandom % 3);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
